// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared widths, defaults and FSM state type for the data-memory responder
package dmem_responder_pkg;

  localparam int WD_SIZE    = 32;
  localparam int DMEM_WORDS = 128;
  localparam int DMEM_LAT   = 2;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_DONE
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage memory port bundle; misalign_err exists only with DMEM_ALIGN_CHK_EN
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic               op_en;
  logic               rd_wr;
  logic [WD_SIZE-1:0] addr;
  logic [WD_SIZE-1:0] wr_data;
  logic [WD_SIZE-1:0] rd_data;
  logic               rd_valid;
  logic               busy;
`ifdef DMEM_ALIGN_CHK_EN
  logic               misalign_err;
`endif

  modport master (
`ifdef DMEM_ALIGN_CHK_EN
    input  misalign_err,
`endif
    output op_en, rd_wr, addr, wr_data,
    input  rd_data, rd_valid, busy
  );

  modport slave (
`ifdef DMEM_ALIGN_CHK_EN
    output misalign_err,
`endif
    input  op_en, rd_wr, addr, wr_data,
    output rd_data, rd_valid, busy
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-wide single-port RAM, synchronous write, combinational read
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS = DMEM_WORDS
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] idx_i,
  input  logic [WD_SIZE-1:0]           wdata_i,
  output logic [WD_SIZE-1:0]           rdata_o
);

  logic [WD_SIZE-1:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the MEM stage
// Optional alignment check enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS  = DMEM_WORDS,
  parameter int LAT_CYCLES = DMEM_LAT
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LAT_CYCLES > 2) ? $clog2(LAT_CYCLES) : 1;

  dmem_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic               mis_q;
  logic [WD_SIZE-1:0] wdata_q;
  logic [WD_SIZE-1:0] rd_data_q;
  logic               rd_valid_q;
  logic               busy_q;

  logic               accept;
  logic               in_mis;
  logic [IDX_W-1:0]   op_idx;
  logic               op_wr;
  logic               op_mis;
  logic [WD_SIZE-1:0] op_wdata;
  logic               enter_done;
  logic               arr_we;
  logic               load_upd;
  logic [WD_SIZE-1:0] arr_rdata;

  wire unused_addr_bits = ^{bus.addr[WD_SIZE-1:IDX_W+2], bus.addr[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
  assign in_mis = (bus.addr[1:0] != 2'b00);
`else
  assign in_mis = 1'b0;
`endif

  assign accept = bus.op_en && (state_q == DMEM_IDLE || state_q == DMEM_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE, DMEM_DONE: begin
        if (bus.op_en) begin
          if (LAT_CYCLES == 1) begin
            state_d = DMEM_DONE;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_W'(LAT_CYCLES - 2);
          end
        end else begin
          state_d = DMEM_IDLE;
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = DMEM_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  // DONE is entered from WAIT (captured request) or, with LAT_CYCLES=1, straight from the accept edge.
  always_comb begin
    op_idx   = idx_q;
    op_wr    = wr_q;
    op_mis   = mis_q;
    op_wdata = wdata_q;
    if (state_q != DMEM_WAIT) begin
      op_idx   = bus.addr[IDX_W+1:2];
      op_wr    = bus.rd_wr;
      op_mis   = in_mis;
      op_wdata = bus.wr_data;
    end
  end

  assign enter_done = (state_d == DMEM_DONE);
  assign arr_we     = enter_done && op_wr && !op_mis && reset_n;
  assign load_upd   = enter_done && !op_wr && !op_mis;

  dmem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .idx_i   (op_idx),
    .wdata_i (op_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= DMEM_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      mis_q      <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if (accept) begin
        idx_q   <= bus.addr[IDX_W+1:2];
        wr_q    <= bus.rd_wr;
        mis_q   <= in_mis;
        wdata_q <= bus.wr_data;
      end
      if (load_upd) begin
        rd_data_q <= arr_rdata;
      end
      rd_valid_q <= enter_done;
      busy_q     <= (state_d == DMEM_WAIT);
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  logic mis_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mis_err_q <= 1'b0;
    end else begin
      mis_err_q <= enter_done && op_mis;
    end
  end

  assign bus.misalign_err = mis_err_q;
`endif

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a word-array model
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int LAT   = 2;
  localparam int WORDS = 128;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .MEM_WORDS  (WORDS),
    .LAT_CYCLES (LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_mem [WORDS];
  bit          model_known [WORDS];
  logic [31:0] model_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_rdata"}, bus.rd_data, model_rd);
`ifdef DMEM_ALIGN_CHK_EN
    check({tag, "_mis"},   32'(bus.misalign_err), 32'd0);
`endif
  endtask

  task automatic idle_cycle();
    bus.op_en = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");
  endtask

  // Issue at a negedge with the responder in IDLE or DONE; returns at the negedge inside the completion cycle.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit hold);
    int          w;
    bit          mis;
    logic [31:0] prev_rd;
    w   = word_of(a);
    mis = is_mis(a);
    prev_rd = model_rd;
    if (!mis) begin
      if (wr) begin
        model_mem[w]   = d;
        model_known[w] = 1'b1;
      end else begin
        model_rd = model_mem[w];
      end
    end
    bus.op_en   = 1'b1;
    bus.rd_wr   = wr;
    bus.addr    = a;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.op_en   = hold;
    bus.rd_wr   = 1'($urandom);
    bus.addr    = $urandom;
    bus.wr_data = $urandom;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        check("wait_busy",  32'(bus.busy), 32'd1);
        check("wait_valid", 32'(bus.rd_valid), 32'd0);
        check("wait_rdata", bus.rd_data, prev_rd);
      end else begin
        check("done_valid", 32'(bus.rd_valid), 32'd1);
        check("done_busy",  32'(bus.busy), 32'd0);
        check("done_rdata", bus.rd_data, model_rd);
`ifdef DMEM_ALIGN_CHK_EN
        check("done_mis",   32'(bus.misalign_err), 32'(mis));
`endif
      end
    end
  endtask

  initial begin
    bit          wr;
    bit          b2b;
    logic [31:0] a;
    reset_n     = 1'b0;
    bus.op_en   = 1'b0;
    bus.rd_wr   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle_outputs("reset_idle");
    end

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    idle_cycle();
    do_req(1'b0, 32'h10, 32'h0, 1'b1);
    idle_cycle();

    do_req(1'b1, 32'h20, 32'h12345678, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 1'b0);
    idle_cycle();

    do_req(1'b1, 32'h200, 32'hA5A5A5A5, 1'b0);
    idle_cycle();
    do_req(1'b0, 32'h000, 32'h0, 1'b0);
    idle_cycle();

    do_req(1'b1, 32'h30, 32'h11111111, 1'b0);
    do_req(1'b0, 32'h30, 32'h0, 1'b0);
    idle_cycle();
    bus.op_en   = 1'b1;
    bus.rd_wr   = 1'b1;
    bus.addr    = 32'h30;
    bus.wr_data = 32'h0BADF00D;
    @(posedge clk);
    #1;
    bus.op_en = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    model_rd = '0;
    reset_n  = 1'b1;
    check_idle_outputs("abort_reset");
    idle_cycle();
    idle_cycle();
    do_req(1'b0, 32'h30, 32'h0, 1'b0);
    idle_cycle();

`ifdef DMEM_ALIGN_CHK_EN
    do_req(1'b1, 32'h40, 32'hCAFEF00D, 1'b0);
    idle_cycle();
    do_req(1'b1, 32'h42, 32'hFFFFFFFF, 1'b0);
    idle_cycle();
    do_req(1'b0, 32'h40, 32'h0, 1'b0);
    idle_cycle();
`endif

    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom);
      a  = $urandom;
      if (!wr && !model_known[word_of(a)] && !is_mis(a)) begin
        wr = 1'b1;
      end
      do_req(wr, a, $urandom, 1'($urandom));
      b2b = 1'($urandom);
      if (!b2b) begin
        idle_cycle();
      end
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
